// File: rtl/ascii_write_arbiter.sv
// Round-robin arbiter sharing the ascii_master_controller write port among NUM_REQ requesters.
// Optional clear-screen sequencer compiled in with `define ASCII_ARB_CLEAR_ENGINE_EN.
module ascii_write_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 32,
  parameter int CELLS   = 4800
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      clear_start,
  output logic                      clear_busy,
  output logic                      ascii_write_en,
  output logic [ADDR_W-1:0]         ascii_write_address,
  output logic [DATA_W-1:0]         ascii_input,
  output logic [15:0]               drop_count
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W:0] CELLS_W = (ADDR_W+1)'(CELLS);

  logic [PTR_W-1:0]  rr_ptr_reg, rr_ptr_next;
  logic [PTR_W-1:0]  winner;
  logic              found;
  logic              busy;
  logic              transfer;
  logic              in_range;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic              wr_en_next;
  logic [ADDR_W-1:0] wr_addr_next;
  logic [DATA_W-1:0] wr_data_next;
  logic [15:0]       drop_next;
  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  logic [DATA_W-1:0] data_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
      assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

`ifdef ASCII_ARB_CLEAR_ENGINE_EN
  typedef enum logic {IDLE, CLEAR} state_t;
  localparam logic [DATA_W-1:0] CLEAR_WORD = DATA_W'({8'h20, 24'hFFFFFF});

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] clr_addr_reg, clr_addr_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      clr_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      clr_addr_reg <= clr_addr_next;
    end
  end

  // A clear_start arriving while already clearing is simply not looked at.
  always_comb begin
    state_next    = state_reg;
    clr_addr_next = clr_addr_reg;
    case (state_reg)
      IDLE: begin
        if (clear_start) begin
          state_next    = CLEAR;
          clr_addr_next = '0;
        end
      end
      CLEAR: begin
        clr_addr_next = clr_addr_reg + ADDR_W'(1);
        if (clr_addr_reg == ADDR_W'(CELLS-1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state_reg == CLEAR);
`else
  logic unused_clear_start;
  assign unused_clear_start = clear_start;
  assign busy = 1'b0;
`endif

  assign clear_busy = busy;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_reg) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = PTR_W'(idx);
      end
    end
  end

  assign win_addr = addr_arr[winner];
  assign win_data = data_arr[winner];
  assign transfer = found && !busy;
  assign in_range = {1'b0, win_addr} < CELLS_W;

  always_comb begin
    req_ready = '0;
    if (transfer && !rst) req_ready[winner] = 1'b1;
  end

  always_comb begin
    wr_en_next   = 1'b0;
    wr_addr_next = ascii_write_address;
    wr_data_next = ascii_input;
    drop_next    = drop_count;
    rr_ptr_next  = rr_ptr_reg;
`ifdef ASCII_ARB_CLEAR_ENGINE_EN
    if (busy) begin
      wr_en_next   = 1'b1;
      wr_addr_next = clr_addr_reg;
      wr_data_next = CLEAR_WORD;
    end
`endif
    if (transfer) begin
      rr_ptr_next = (winner == PTR_W'(NUM_REQ-1)) ? '0 : winner + PTR_W'(1);
      if (in_range) begin
        wr_en_next   = 1'b1;
        wr_addr_next = win_addr;
        wr_data_next = win_data;
      end else if (drop_count != 16'hFFFF) begin
        drop_next = drop_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg          <= '0;
      ascii_write_en      <= 1'b0;
      ascii_write_address <= '0;
      ascii_input         <= '0;
      drop_count          <= '0;
    end else begin
      rr_ptr_reg          <= rr_ptr_next;
      ascii_write_en      <= wr_en_next;
      ascii_write_address <= wr_addr_next;
      ascii_input         <= wr_data_next;
      drop_count          <= drop_next;
    end
  end

endmodule

// File: tb/tb_ascii_write_arbiter.sv
// Scoreboard bench for ascii_write_arbiter: stimulus pushes expected writes, a monitor pops them.
// Clear-sequencer checks are built when ASCII_ARB_CLEAR_ENGINE_EN is defined.
module tb_ascii_write_arbiter;
  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 13;
  localparam int DATA_W  = 32;
  localparam int CELLS   = 4800;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data = '0;
  logic                      clear_start = 1'b0;
  logic                      clear_busy;
  logic                      ascii_write_en;
  logic [ADDR_W-1:0]         ascii_write_address;
  logic [DATA_W-1:0]         ascii_input;
  logic [15:0]               drop_count;

  int vectors = 0;
  int miscompares = 0;
  bit mon_en = 1'b1;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  ascii_write_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CELLS(CELLS)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .clear_start(clear_start),
    .clear_busy(clear_busy), .ascii_write_en(ascii_write_en),
    .ascii_write_address(ascii_write_address), .ascii_input(ascii_input),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [12:0] a0, input logic [31:0] d0,
                       input logic [12:0] a1, input logic [31:0] d1);
    req_valid = v;
    req_addr  = {a1, a0};
    req_data  = {d1, d0};
  endtask

  task automatic push(input logic [12:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // Monitor: each observed write must match the oldest expected one.
  always @(negedge clk) begin
    logic [ADDR_W+DATA_W-1:0] e;
    if (!rst && mon_en && ascii_write_en) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got addr %0d data %h expected no write",
                 ascii_write_address, ascii_input);
      end else begin
        e = exp_q.pop_front();
        if ({ascii_write_address, ascii_input} !== e) begin
          miscompares++;
          $display("FAIL write: got addr %0d data %h expected addr %0d data %h",
                   ascii_write_address, ascii_input, e[44:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    int busy_cycles;
    // Reset state, with both requesters asking
    drive(2'b11, 13'd1, 32'h1, 13'd2, 32'h2);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_wen", 64'(ascii_write_en), 64'h0);
    chk("rst_addr", 64'(ascii_write_address), 64'h0);
    chk("rst_data", 64'(ascii_input), 64'h0);
    chk("rst_busy", 64'(clear_busy), 64'h0);
    chk("rst_drop", 64'(drop_count), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(2'b00, 13'd0, 32'h0, 13'd0, 32'h0);

    // Single write from requester 0
    @(negedge clk);
    drive(2'b01, 13'd5, 32'h41FFFFFF, 13'd0, 32'h0);
    #1;
    chk("single_ready", 64'(req_ready), 64'h1);
    push(13'd5, 32'h41FFFFFF);
    @(negedge clk);
    drive(2'b00, 13'd0, 32'h0, 13'd0, 32'h0);
    #1;
    chk("single_wen", 64'(ascii_write_en), 64'h1);
    @(negedge clk);
    #1;
    chk("single_wen_low", 64'(ascii_write_en), 64'h0);
    chk("single_addr_hold", 64'(ascii_write_address), 64'd5);

    // Asynchronous reset mid-stream
    @(negedge clk);
    drive(2'b01, 13'd9, 32'h44556677, 13'd0, 32'h0);
    #1;
    push(13'd9, 32'h44556677);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_wen", 64'(ascii_write_en), 64'h0);
    chk("arst_addr", 64'(ascii_write_address), 64'h0);
    chk("arst_data", 64'(ascii_input), 64'h0);
    chk("arst_ready", 64'(req_ready), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(2'b00, 13'd0, 32'h0, 13'd0, 32'h0);

    // Fairness: both valid, grants alternate starting at 0
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(2'b11, 13'(10 + i), 32'h30AA0000 + 32'(i), 13'(20 + i), 32'h31BB0000 + 32'(i));
      #1;
      if (i % 2 == 0) begin
        chk("rr_ready", 64'(req_ready), 64'h1);
        push(13'(10 + i), 32'h30AA0000 + 32'(i));
      end else begin
        chk("rr_ready", 64'(req_ready), 64'h2);
        push(13'(20 + i), 32'h31BB0000 + 32'(i));
      end
    end

    // Out-of-range address is handshaken and dropped
    @(negedge clk);
    drive(2'b10, 13'd0, 32'h0, 13'd4800, 32'h45000000);
    #1;
    chk("drop_ready", 64'(req_ready), 64'h2);
    @(negedge clk);
    drive(2'b10, 13'd0, 32'h0, 13'd4799, 32'h42123456);
    #1;
    chk("drop_count", 64'(drop_count), 64'h1);
    chk("drop_wen", 64'(ascii_write_en), 64'h0);
    chk("last_cell_ready", 64'(req_ready), 64'h2);
    push(13'd4799, 32'h42123456);
    // Lone requester 1 accepted every cycle, search wraps past pointer 0
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(2'b10, 13'd0, 32'h0, 13'(100 + i), 32'h50000000 + 32'(i));
      #1;
      chk("lone_ready", 64'(req_ready), 64'h2);
      push(13'(100 + i), 32'h50000000 + 32'(i));
    end
    @(negedge clk);
    drive(2'b00, 13'd0, 32'h0, 13'd0, 32'h0);
    #1;
    chk("drop_hold", 64'(drop_count), 64'h1);

`ifdef ASCII_ARB_CLEAR_ENGINE_EN
    // Clear with requester 0 held valid; its write on the start cycle still goes through
    @(negedge clk);
    drive(2'b01, 13'd7, 32'h43000000, 13'd0, 32'h0);
    clear_start = 1'b1;
    #1;
    chk("clr_start_ready", 64'(req_ready), 64'h1);
    push(13'd7, 32'h43000000);
    for (int a = 0; a < CELLS; a++) push(13'(a), 32'h20FFFFFF);
    busy_cycles = 0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      clear_start = 1'b0;
      #1;
      if (!clear_busy) break;
      busy_cycles++;
      if (req_ready != 2'b00) chk("clr_ready_low", 64'(req_ready), 64'h0);
      if (busy_cycles == 100) clear_start = 1'b1;
    end
    chk("clr_busy_len", 64'(busy_cycles), 64'(CELLS));
    chk("clr_after_ready", 64'(req_ready), 64'h1);
    push(13'd7, 32'h43000000);
    @(negedge clk);
    drive(2'b00, 13'd0, 32'h0, 13'd0, 32'h0);
    repeat (2) @(negedge clk);

    // Reset mid-clear
    mon_en = 1'b0;
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    repeat (2000) @(negedge clk);
    drive(2'b01, 13'd3, 32'h46000000, 13'd0, 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("mid_clr_busy", 64'(clear_busy), 64'h0);
    chk("mid_clr_wen", 64'(ascii_write_en), 64'h0);
    chk("mid_clr_addr", 64'(ascii_write_address), 64'h0);
    chk("mid_clr_drop", 64'(drop_count), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(2'b00, 13'd0, 32'h0, 13'd0, 32'h0);
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("post_rst_idle", 64'(clear_busy), 64'h0);
    drive(2'b01, 13'd3, 32'h46000000, 13'd0, 32'h0);
    #1;
    chk("post_rst_ready", 64'(req_ready), 64'h1);
    push(13'd3, 32'h46000000);
    @(negedge clk);
    drive(2'b00, 13'd0, 32'h0, 13'd0, 32'h0);
`else
    // Without the clear engine, clear_start has no effect on traffic
    busy_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(2'b01, 13'(200 + i), 32'h47000000 + 32'(i), 13'd0, 32'h0);
      clear_start = (i == 0);
      #1;
      chk("noclr_ready", 64'(req_ready), 64'h1);
      chk("noclr_busy", 64'(clear_busy), 64'h0);
      push(13'(200 + i), 32'h47000000 + 32'(i));
    end
    @(negedge clk);
    clear_start = 1'b0;
    drive(2'b00, 13'd0, 32'h0, 13'd0, 32'h0);
    #1;
    chk("noclr_busy_after", 64'(clear_busy), 64'(busy_cycles));
`endif

    repeat (3) @(negedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
